// File: rtl/team_gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : team_gpio_pkg
// Purpose  : Shared constants, register index encoding and the bank slicing
//            helper for the team GPIO controller.
// Contents : DATA_W, REG_IDX_W, gpio_reg_e, bank_slice()
// Revision : 1.0 - initial release
// ============================================================================
package team_gpio_pkg;

  localparam int DATA_W    = 32;
  localparam int REG_IDX_W = 3;

  // Register index carried in bus_addr[3:1].
  typedef enum logic [REG_IDX_W-1:0] {
    OUT     = 3'd0,
    OE      = 3'd1,
    IN      = 3'd2,
    RISE_EN = 3'd3,
    FALL_EN = 3'd4,
    STATUS  = 3'd5,
    IRQ_EN  = 3'd6,
    OUT_TGL = 3'd7
  } gpio_reg_e;

  // Selects the 32-bit bank view of a 64-bit pin vector.
  function automatic logic [DATA_W-1:0] bank_slice(input logic [2*DATA_W-1:0] v,
                                                   input logic               bank);
    return bank ? v[2*DATA_W-1:DATA_W] : v[DATA_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_sync.sv
`default_nettype none
// ============================================================================
// Module   : gpio_sync
// Purpose  : Multi-stage input synchroniser followed by a previous-sample
//            register, producing synchronised level and edge strobes.
// Ports    : clk, rst       - clock, synchronous active-high reset
//            d    [WIDTH]   - asynchronous pad inputs
//            sync [WIDTH]   - last synchroniser stage
//            rise [WIDTH]   - sync & ~prev
//            fall [WIDTH]   - ~sync & prev
// Revision : 1.0 - initial release
// ============================================================================
module gpio_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q, stage_d;
  logic [WIDTH-1:0]             prev_q, prev_d;

  always_comb begin
    stage_d = {stage_q[STAGES-2:0], d};
    prev_d  = stage_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
      prev_q  <= '0;
    end else begin
      stage_q <= stage_d;
      prev_q  <= prev_d;
    end
  end

  assign sync = stage_q[STAGES-1];
  assign rise = sync & ~prev_q;
  assign fall = ~sync & prev_q;

endmodule
`default_nettype wire

// File: rtl/team_gpio_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : team_gpio_ctrl
// Purpose  : Register-programmable GPIO pin bank with output/enable registers,
//            synchronised inputs, edge capture (W1C status) and level irq.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            en                  - block enable (low: pads input, capture off)
//            bus_addr[3:0]       - {reg_idx[2:0], bank}
//            bus_we, bus_re      - write / read strobes
//            bus_wdata[31:0]     - write data
//            bus_rdata[31:0]     - registered read data
//            bus_rvalid          - one-cycle pulse with bus_rdata
//            irq                 - registered level interrupt
//            gpio_in/out/oeb     - pad input, output, active-low enable
// Revision : 1.0 - initial release
// ============================================================================
module team_gpio_ctrl
  import team_gpio_pkg::*;
#(
  parameter int NUM_PINS    = 34,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [3:0]          bus_addr,
  input  logic                bus_we,
  input  logic                bus_re,
  input  logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W-1:0]   bus_rdata,
  output logic                bus_rvalid,
  output logic                irq,
  input  logic [NUM_PINS-1:0] gpio_in,
  output logic [NUM_PINS-1:0] gpio_out,
  output logic [NUM_PINS-1:0] gpio_oeb
);

  gpio_reg_e reg_idx;
  logic      bank;
  assign reg_idx = gpio_reg_e'(bus_addr[3:1]);
  assign bank    = bus_addr[0];

  logic [NUM_PINS-1:0] sync_in, rise, fall;

  gpio_sync #(
    .WIDTH  (NUM_PINS),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (gpio_in),
    .sync (sync_in),
    .rise (rise),
    .fall (fall)
  );

  // Per-pin view of the write data: the bus bit that lands on each pin and
  // whether the addressed bank covers it. Pins beyond NUM_PINS do not exist.
  logic [NUM_PINS-1:0] wr_bit, wr_hit;
  for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
    assign wr_bit[i] = bus_wdata[i % DATA_W];
    assign wr_hit[i] = (bank == 1'(i / DATA_W));
  end

  logic [NUM_PINS-1:0] wr_set, wr_keep;
  assign wr_set  = wr_bit & wr_hit;
  assign wr_keep = ~wr_hit;

  logic [NUM_PINS-1:0] out_q, out_d, oe_q, oe_d;
  logic [NUM_PINS-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [NUM_PINS-1:0] status_q, status_d, irq_en_q, irq_en_d;
  logic [NUM_PINS-1:0] ev_set;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d, irq_q, irq_d;
  logic [2*DATA_W-1:0] rd_sel;

  always_comb begin
    out_d     = out_q;
    oe_d      = oe_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    irq_en_d  = irq_en_q;
    ev_set    = en ? ((rise & rise_en_q) | (fall & fall_en_q)) : '0;
    status_d  = status_q;

    if (bus_we) begin
      case (reg_idx)
        OUT:     out_d     = (out_q & wr_keep) | wr_set;
        OE:      oe_d      = (oe_q & wr_keep) | wr_set;
        RISE_EN: rise_en_d = (rise_en_q & wr_keep) | wr_set;
        FALL_EN: fall_en_d = (fall_en_q & wr_keep) | wr_set;
        STATUS:  status_d  = status_q & ~wr_set;
        IRQ_EN:  irq_en_d  = (irq_en_q & wr_keep) | wr_set;
        OUT_TGL: out_d     = out_q ^ wr_set;
        default: ;
      endcase
    end
    // OR-ing new events after the clear lets a same-cycle event win over W1C.
    status_d = status_d | ev_set;

    // Reads sample the pre-write register values.
    rd_sel = '0;
    case (reg_idx)
      OUT:     rd_sel[NUM_PINS-1:0] = out_q;
      OE:      rd_sel[NUM_PINS-1:0] = oe_q;
      IN:      rd_sel[NUM_PINS-1:0] = sync_in;
      RISE_EN: rd_sel[NUM_PINS-1:0] = rise_en_q;
      FALL_EN: rd_sel[NUM_PINS-1:0] = fall_en_q;
      STATUS:  rd_sel[NUM_PINS-1:0] = status_q;
      IRQ_EN:  rd_sel[NUM_PINS-1:0] = irq_en_q;
      default: rd_sel = '0;
    endcase
    rdata_d  = bus_re ? bank_slice(rd_sel, bank) : rdata_q;
    rvalid_d = bus_re;
    irq_d    = |(status_q & irq_en_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= '0;
      oe_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      irq_en_q  <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      oe_q      <= oe_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      irq_en_q  <= irq_en_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      irq_q     <= irq_d;
    end
  end

  assign bus_rdata  = rdata_q;
  assign bus_rvalid = rvalid_q;
  assign irq        = irq_q;
  assign gpio_out   = en ? out_q : '0;
  assign gpio_oeb   = en ? ~oe_q : '1;

endmodule
`default_nettype wire

// File: tb/tb_team_gpio_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_team_gpio_ctrl
// Purpose  : Directed self-checking bench for team_gpio_ctrl (34-pin and
//            16-pin instances sharing one bus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_team_gpio_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, bus_we, bus_re;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [33:0] gpio_in;
  logic [15:0] gpio_in16;

  logic [31:0] rdata, rdata16;
  logic        rvalid, rvalid16, irq, irq16;
  logic [33:0] gpio_out, gpio_oeb;
  logic [15:0] gpio_out16, gpio_oeb16;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  team_gpio_ctrl #(.NUM_PINS(34), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .en(en), .bus_addr(bus_addr), .bus_we(bus_we),
    .bus_re(bus_re), .bus_wdata(bus_wdata), .bus_rdata(rdata),
    .bus_rvalid(rvalid), .irq(irq), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .gpio_oeb(gpio_oeb)
  );

  team_gpio_ctrl #(.NUM_PINS(16), .SYNC_STAGES(2)) dut16 (
    .clk(clk), .rst(rst), .en(en), .bus_addr(bus_addr), .bus_we(bus_we),
    .bus_re(bus_re), .bus_wdata(bus_wdata), .bus_rdata(rdata16),
    .bus_rvalid(rvalid16), .irq(irq16), .gpio_in(gpio_in16),
    .gpio_out(gpio_out16), .gpio_oeb(gpio_oeb16)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  function automatic logic [3:0] a(input int idx, input int bank);
    return {3'(idx), 1'(bank)};
  endfunction

  // Both tasks start and end on a falling edge; the strobe is sampled on the
  // rising edge in between.
  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus_addr = addr; bus_wdata = data; bus_we = 1'b1;
    @(negedge clk);
    bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] addr);
    @(negedge clk);
    bus_addr = addr; bus_re = 1'b1;
    @(negedge clk);
    bus_re = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; bus_we = 1'b0; bus_re = 1'b0;
    bus_addr = '0; bus_wdata = '0; gpio_in = '0; gpio_in16 = '0;
    repeat (3) @(negedge clk);
    check("rst_oeb",    64'(gpio_oeb), 64'h3_FFFF_FFFF);
    check("rst_out",    64'(gpio_out), 64'h0);
    check("rst_irq",    64'(irq), 64'h0);
    check("rst_rvalid", 64'(rvalid), 64'h0);
    rst = 1'b0;

    for (int r = 0; r < 16; r++) begin
      bus_read(4'(r));
      check("rst_rd_valid", 64'(rvalid), 64'h1);
      check("rst_rd_data",  64'(rdata), 64'h0);
    end
    @(negedge clk);
    check("rvalid_pulse", 64'(rvalid), 64'h0);

    // Output drive and toggle.
    bus_write(a(1, 0), 32'h0000_00FF);
    bus_write(a(0, 0), 32'h0000_00A5);
    check("oeb_drive", 64'(gpio_oeb), 64'h3_FFFF_FF00);
    check("out_a5",    64'(gpio_out), 64'h0_0000_00A5);
    bus_write(a(7, 0), 32'h0000_000F);
    check("out_tgl",   64'(gpio_out), 64'h0_0000_00AA);
    bus_read(a(7, 0));
    check("tgl_reads0", 64'(rdata), 64'h0);
    bus_read(a(0, 0));
    check("out_rd",     64'(rdata), 64'hAA);

    // Enable gating is combinational; registers hold their values.
    @(negedge clk);
    en = 1'b0;
    #1;
    check("en0_oeb", 64'(gpio_oeb), 64'h3_FFFF_FFFF);
    check("en0_out", 64'(gpio_out), 64'h0);
    bus_read(a(0, 0));
    check("en0_out_kept", 64'(rdata), 64'hAA);
    en = 1'b1;
    #1;
    check("en1_out", 64'(gpio_out), 64'h0_0000_00AA);

    // Rising edge on pin 33: status after 3 cycles, irq after 4.
    bus_write(a(3, 1), 32'h2);
    bus_write(a(6, 1), 32'h2);
    @(negedge clk);
    gpio_in[33] = 1'b1;
    repeat (3) @(negedge clk);
    check("irq_not_yet", 64'(irq), 64'h0);
    @(negedge clk);
    check("irq_set", 64'(irq), 64'h1);
    bus_read(a(5, 1));
    check("status_b1", 64'(rdata), 64'h2);
    bus_read(a(2, 1));
    check("in_b1", 64'(rdata), 64'h2);
    bus_write(a(5, 1), 32'h2);
    check("irq_w1c_lag", 64'(irq), 64'h1);
    @(negedge clk);
    check("irq_cleared", 64'(irq), 64'h0);
    bus_read(a(5, 1));
    check("status_b1_clr", 64'(rdata), 64'h0);

    // Edge while disabled is lost; first edge after enable is captured.
    bus_write(a(3, 0), 32'h20);
    @(negedge clk);
    en = 1'b0;
    gpio_in[5] = 1'b1;
    repeat (4) @(negedge clk);
    gpio_in[5] = 1'b0;
    repeat (4) @(negedge clk);
    en = 1'b1;
    repeat (2) @(negedge clk);
    bus_read(a(5, 0));
    check("en0_edge_lost", 64'(rdata), 64'h0);
    gpio_in[5] = 1'b1;
    repeat (4) @(negedge clk);
    bus_read(a(5, 0));
    check("en1_edge_cap", 64'(rdata), 64'h20);
    bus_write(a(5, 0), 32'h20);

    // Set wins over same-cycle W1C.
    bus_write(a(4, 0), 32'h1);
    @(negedge clk);
    gpio_in[0] = 1'b1;
    repeat (4) @(negedge clk);
    gpio_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    bus_read(a(5, 0));
    check("fall_cap", 64'(rdata), 64'h1);
    gpio_in[0] = 1'b1;
    repeat (4) @(negedge clk);
    gpio_in[0] = 1'b0;
    @(negedge clk);
    bus_write(a(5, 0), 32'h1);
    bus_read(a(5, 0));
    check("set_wins", 64'(rdata), 64'h1);
    bus_write(a(5, 0), 32'h1);
    bus_read(a(5, 0));
    check("w1c_plain", 64'(rdata), 64'h0);

    // Simultaneous write and read of OUT.
    @(negedge clk);
    bus_addr = a(0, 0); bus_wdata = 32'h1234_5678; bus_we = 1'b1; bus_re = 1'b1;
    @(negedge clk);
    bus_we = 1'b0; bus_re = 1'b0;
    check("wr_rd_valid", 64'(rvalid), 64'h1);
    check("wr_rd_old",   64'(rdata), 64'hAA);
    bus_read(a(0, 0));
    check("wr_rd_new",   64'(rdata), 64'h1234_5678);
    check("out_new_pad", 64'(gpio_out), 64'h0_1234_5678);

    // Reset with a pending read drops the read.
    @(negedge clk);
    rst = 1'b1; bus_re = 1'b1; bus_addr = a(0, 0);
    @(negedge clk);
    rst = 1'b0; bus_re = 1'b0;
    check("rst_drop_rvalid", 64'(rvalid), 64'h0);
    check("rst_mid_out",     64'(gpio_out), 64'h0);
    check("rst_mid_oeb",     64'(gpio_oeb), 64'h3_FFFF_FFFF);
    bus_read(a(0, 0));
    check("rst_mid_rd", 64'(rdata), 64'h0);

    // Bank 1 inert on a 16-pin instance; 34-pin keeps only bits 32..33.
    bus_write(a(0, 1), 32'hFFFF_FFFF);
    bus_read(a(0, 1));
    check("b1_34pin",      64'(rdata), 64'h3);
    check("b1_16pin",      64'(rdata16), 64'h0);
    check("b1_16pin_valid", 64'(rvalid16), 64'h1);
    bus_write(a(0, 0), 32'hFFFF_FFFF);
    bus_read(a(0, 0));
    check("b0_16pin",     64'(rdata16), 64'hFFFF);
    check("b0_34pin",     64'(rdata), 64'hFFFF_FFFF);
    check("pad_16pin",    64'(gpio_out16), 64'hFFFF);
    check("oeb_16pin",    64'(gpio_oeb16), 64'hFFFF);
    check("irq_16pin",    64'(irq16), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/team_gpio_ctrl.md
# team_gpio_ctrl

Parametrised GPIO controller that replaces the fixed tie-off of the team top-level pins with a register-programmable pin bank. It sits between the team's core logic (register bus master) and the breakout-board GPIO pads. It provides per-pin output/enable registers, synchronised inputs, edge capture with write-1-to-clear status, and a level interrupt.

## Interface
Parameters:
- NUM_PINS, 34: number of GPIO pins, legal range 1..64.
- SYNC_STAGES, 2: input synchroniser depth, legal range 2..4.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  block enable; low forces pads to input and freezes edge capture.
- bus_addr  in  4  word address: {reg_idx[2:0], bank}.
- bus_we  in  1  write strobe.
- bus_re  in  1  read strobe.
- bus_wdata  in  32  write data.
- bus_rdata  out  32  read data, registered.
- bus_rvalid  out  1  one-cycle pulse with bus_rdata.
- irq  out  1  level interrupt, registered.
- gpio_in  in  NUM_PINS  pad inputs.
- gpio_out  out  NUM_PINS  pad outputs.
- gpio_oeb  out  NUM_PINS  active-low output enable.

## Operation
- Register map, reg_idx: 0 OUT (rw), 1 OE (rw, 1 = drive), 2 IN (ro), 3 RISE_EN (rw), 4 FALL_EN (rw), 5 STATUS (rw1c), 6 IRQ_EN (rw), 7 OUT_TGL (wo, write-1 toggles OUT bit; reads 0).
- bank 0 maps pins 0..31 and bank 1 maps pins 32..63. Bits at or above NUM_PINS are not stored and read 0. Bank 1 is fully inert when NUM_PINS ≤ 32.
- gpio_out = en ? OUT : 0. gpio_oeb = en ? ~OE : all-ones.
- Synchroniser chain and previous-sample register always run, whether or not en is high.
- IN is the last synchroniser stage.
- Rising edge on pin i is (sync_i & ~prev_i). Falling edge is the inverse.
- STATUS[i] sets when en && ((rise_i && RISE_EN[i]) || (fall_i && FALL_EN[i])).
- irq = |(STATUS & IRQ_EN), registered.
- Simultaneous STATUS set event and W1C on the same bit: set wins, bit stays 1.
- Simultaneous OUT write and OUT_TGL cannot occur (single address). Toggle uses the current OUT value.
- bus_we and bus_re in the same cycle: the write is applied, and the read returns the pre-write value.
- Writes to IN or to unmapped bits are ignored.
- Reset: OUT, OE, RISE_EN, FALL_EN, STATUS, IRQ_EN = 0. Synchroniser and prev = 0.
- Outputs at reset: gpio_out = 0, gpio_oeb = all-ones, irq = 0, bus_rdata = 0, bus_rvalid = 0.
- rst mid-operation: all of the above take effect on the next edge. A pending read is dropped, so no rvalid is produced.

## Timing
- Register write visible on gpio_out/gpio_oeb the cycle after the bus_we edge.
- Read latency 1: bus_rdata/bus_rvalid are valid in the cycle after bus_re. Back-to-back reads are allowed every cycle.
- Pad change to IN readable: SYNC_STAGES cycles.
- Pad change to STATUS set: SYNC_STAGES+1 cycles. irq asserts one cycle after that.
- W1C clears STATUS the cycle after the write. irq deasserts one cycle later, unless a new event occurs.
- en low to pads released: same cycle (combinational gating of registered values).
- Edge present during en low is lost, not deferred. The first edge after en rises is captured normally.

## Structure
- Package team_gpio_pkg contains:
  - DATA_W = 32 and REG_IDX_W = 3.
  - Enum gpio_reg_e: OUT, OE, IN, RISE_EN, FALL_EN, STATUS, IRQ_EN, OUT_TGL.
  - Helper function for the bank bit-slice.
- Sub-module gpio_sync (parameters WIDTH, STAGES): the synchroniser chain plus prev register. It outputs sync, rise, fall.
- Top level holds the register file, read mux and irq logic.

## Test plan
- Reset with NUM_PINS = 34:
  - gpio_oeb = 34'h3_FFFF_FFFF, gpio_out = 0, irq = 0.
  - Read of every register -> 0 with rvalid one cycle after re.
- Write OE bank0 = 0x0000_00FF and OUT bank0 = 0x0000_00A5 with en = 1:
  - gpio_oeb[7:0] = 0, gpio_out[7:0] = 8'hA5.
  - Then write OUT_TGL = 0x0F -> gpio_out[7:0] = 8'hAA.
- en = 0: gpio_oeb all-ones and gpio_out = 0 while the registers keep their values. en = 1 restores 8'hAA.
- Edge capture with RISE_EN[33] = 1 and IRQ_EN[33] = 1:
  - Raise gpio_in[33] -> STATUS bank1 bit1 set after 3 cycles, irq after 4.
  - W1C 0x2 -> irq drops two cycles later.
- Set-wins: fall edge on pin 0 (FALL_EN[0] = 1) in the same cycle as W1C of bit 0 -> STATUS[0] remains 1.
- Pulse gpio_in[5] high then low while en = 0 with RISE_EN[5] = 1 -> STATUS stays 0.
- Same-cycle we/re on OUT -> rdata holds the old value, and the next read holds the new value.
- Write bank1 when NUM_PINS = 16 -> reads return 0.
